// File: rtl/float_accumulator_e4m3.sv
// E4M3 stream accumulator: exact wide fixed-point sum, one RNE rounding per packet.
// Overflow result: E4M3_ACC_SATURATE_EN defined -> +-448, undefined -> NaN (0x7F).
module float_accumulator_e4m3 #(
    parameter int GUARD_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GUARD_BITS:0]   out_terms
);

    localparam int ACC_W = 19 + GUARD_BITS;
    localparam int PW    = $clog2(ACC_W);
    localparam int EW    = PW + 1;

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]                state;
    logic signed [ACC_W-1:0]   acc;
    logic                      nan_q, ovf_q;
    logic [GUARD_BITS:0]       count;

    assign in_ready = (state == ST_ACCUM);

    // term decode: magnitude in units of 2^-9
    logic [3:0]                in_e;
    logic [2:0]                in_m;
    logic [17:0]               mag;
    logic signed [ACC_W-1:0]   mag_ext, term, sum;
    logic                      add_ovf, beat, term_nan;

    always_comb begin
        in_e     = in_data[6:3];
        in_m     = in_data[2:0];
        mag      = (in_e == 4'd0) ? {15'd0, in_m} : (18'({1'b1, in_m}) << (in_e - 4'd1));
        mag_ext  = {{(ACC_W-18){1'b0}}, mag};
        term     = in_data[7] ? -mag_ext : mag_ext;
        sum      = acc + term;
        add_ovf  = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        term_nan = (in_e == 4'd15) && (in_m == 3'd7);
        beat     = in_valid && in_ready;
    end

    // sum -> E4M3 conversion
    logic [ACC_W-1:0]  a, norm;
    logic [PW-1:0]     p;
    logic [2:0]        mant, mant_r;
    logic              carry, rnd, res_s, ovf_fmt;
    logic [EW-1:0]     exp_r;
    logic [7:0]        ovf_code, res;

    always_comb begin
        res_s = acc[ACC_W-1];
        a     = res_s ? $unsigned(-acc) : $unsigned(acc);
        p     = '0;
        for (int i = 0; i < ACC_W; i++)
            if (a[i]) p = PW'(i);
        // left-justify so mantissa/guard/sticky sit at fixed positions
        norm  = a << (PW'(ACC_W-1) - p);
        mant  = norm[ACC_W-2 -: 3];
        rnd   = norm[ACC_W-5] & ((|norm[ACC_W-6:0]) | mant[0]);
        {carry, mant_r} = {1'b0, mant} + {3'b000, rnd};
        exp_r = EW'(p) - EW'(2) + EW'(carry);
        if (p < PW'(3)) begin
            exp_r  = '0;
            mant_r = a[2:0];
        end
        ovf_fmt = (exp_r > EW'(15)) || ((exp_r == EW'(15)) && (mant_r == 3'd7));
`ifdef E4M3_ACC_SATURATE_EN
        ovf_code = {res_s, 7'h7E};
`else
        ovf_code = 8'h7F;
`endif
        if (nan_q)                 res = 8'h7F;
        else if (ovf_q || ovf_fmt) res = ovf_code;
        else if (acc == '0)        res = 8'h00;
        else                       res = {res_s, exp_r[3:0], mant_r};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            nan_q     <= 1'b0;
            ovf_q     <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_terms <= '0;
        end else begin
            case (state)
                ST_ACCUM: if (beat) begin
                    // clamping keeps the sign of the overflowing term in acc
                    acc   <= add_ovf ? (term[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
                    nan_q <= nan_q | term_nan;
                    ovf_q <= ovf_q | add_ovf;
                    if (count != '1) count <= count + 1'b1;
                    if (in_last) state <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    out_data  <= res;
                    out_terms <= count;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    nan_q     <= 1'b0;
                    ovf_q     <= 1'b0;
                    count     <= '0;
                    state     <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_float_accumulator_e4m3.sv
// Scoreboard bench for float_accumulator_e4m3: directed packets with hand-computed sums.
module tb_float_accumulator_e4m3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_terms;

    float_accumulator_e4m3 #(.GUARD_BITS(8)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_terms(out_terms)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic [8:0] terms;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

`ifdef E4M3_ACC_SATURATE_EN
    localparam logic [7:0] OVF_POS = 8'h7E;
`else
    localparam logic [7:0] OVF_POS = 8'h7F;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    // monitor: compare every delivered result against the scoreboard
    always @(negedge clock) begin
        if (reset) begin
            check("valid_ready_excl", {31'd0, out_valid & in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: actual=%0h required=none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_terms", {23'd0, out_terms}, {23'd0, e.terms});
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) timeout_fail("send");
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!(out_valid && out_ready) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) timeout_fail("wait_out");
        @(posedge clock);
        #1;
    endtask

    task automatic pkt(input int n, input logic [7:0] t0, input logic [7:0] t1,
                       input logic [7:0] t2, input logic [7:0] ed, input logic [8:0] et);
        sb.push_back('{data: ed, terms: et});
        send(t0, n == 1);
        if (n > 1) send(t1, n == 2);
        if (n > 2) send(t2, 1'b1);
        wait_out();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_terms", {23'd0, out_terms}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 2 + 2 = 4, with latency check
        sb.push_back('{data: 8'h48, terms: 9'd2});
        send(8'h40, 1'b0);
        send(8'h40, 1'b1);
        check("lat_edge_n", {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        check("lat_edge_n1", {31'd0, out_valid}, 32'd1);
        check("lat_in_ready", {31'd0, in_ready}, 32'd0);
        wait_out();

        pkt(2, 8'h48, 8'hC0, 8'h00, 8'h40, 9'd2);   // 4 - 2 = 2
        pkt(1, 8'h80, 8'h00, 8'h00, 8'h00, 9'd1);   // -0
        pkt(2, 8'hC8, 8'h40, 8'h00, 8'hC0, 9'd2);   // -4 + 2 = -2
        pkt(2, 8'h7E, 8'h7E, 8'h00, OVF_POS, 9'd2); // 896 overflows format
        pkt(3, 8'h01, 8'h7F, 8'h38, 8'h7F, 9'd3);   // sticky NaN
        pkt(2, 8'h38, 8'h18, 8'h00, 8'h38, 9'd2);   // tie -> even, down
        pkt(2, 8'h39, 8'h18, 8'h00, 8'h3A, 9'd2);   // tie -> even, up
        pkt(2, 8'h01, 8'h02, 8'h00, 8'h03, 9'd2);   // exact subnormal

        // backpressure
        out_ready = 1'b0;
        sb.push_back('{data: 8'h48, terms: 9'd2});
        send(8'h40, 1'b0);
        send(8'h40, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) timeout_fail("bp_valid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_hold_data", {24'd0, out_data}, 32'h48);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("hs_in_ready", {31'd0, in_ready}, 32'd1);

        // mid-packet reset discards the partial sum
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_data", {24'd0, out_data}, 32'd0);
        check("mrst_out_terms", {23'd0, out_terms}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        pkt(1, 8'h38, 8'h00, 8'h00, 8'h38, 9'd1);

        repeat (5) @(posedge clock);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
